// File: rtl/maindec_mc.sv
// rtl/maindec_mc.sv - multicycle main decoder FSM with mem_ready stalls
//
// Steps each instruction through fetch, decode, execute, memory and writeback.
// Ports:
//   clk, reset_n      : clock and asynchronous active-low reset
//   en                : run enable; low holds state and blocks all write enables
//   op                : opcode from the instruction register, sampled in DECODE
//   mem_ready         : memory completes the current access this cycle
//   memread..alusrca  : 1-bit datapath controls
//   alusrcb/aluop/pcsrc : 2-bit datapath controls
//   instr_done        : pulse in the final cycle of a legal instruction
//   illegal           : sticky unknown-opcode flag
//   state             : current FSM state for debug
module maindec_mc #(
    parameter int             OPW      = 4,
    parameter logic [OPW-1:0] OP_RTYPE = OPW'(0),
    parameter logic [OPW-1:0] OP_ADDI  = OPW'(1),
    parameter logic [OPW-1:0] OP_LW    = OPW'(12),
    parameter logic [OPW-1:0] OP_SW    = OPW'(14),
    parameter logic [OPW-1:0] OP_BEQ   = OPW'(10),
    parameter logic [OPW-1:0] OP_J     = OPW'(8)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic [OPW-1:0] op,
    input  logic           mem_ready,
    output logic           memread,
    output logic           memwrite,
    output logic           irwrite,
    output logic           pcwrite,
    output logic           branch,
    output logic           iord,
    output logic           memtoreg,
    output logic           regdst,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     aluop,
    output logic [1:0]     pcsrc,
    output logic           instr_done,
    output logic           illegal,
    output logic [3:0]     state
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_EXEC    = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BEQ     = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;
    localparam logic [3:0] S_ILLEGAL = 4'd13;

    logic [3:0]     state_q, state_d;
    logic [OPW-1:0] opreg_q, opreg_d;
    logic           illegal_q, illegal_d;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            opreg_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opreg_q   <= opreg_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; with en low everything holds, including stalled accesses
    always_comb begin
        state_d   = state_q;
        opreg_d   = opreg_q;
        illegal_d = illegal_q;
        if (en) begin
            case (state_q)
                S_IDLE:   state_d = S_FETCH;
                S_FETCH:  if (mem_ready) state_d = S_DECODE;
                S_DECODE: begin
                    opreg_d = op;
                    if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                    else if (op == OP_RTYPE)        state_d = S_EXEC;
                    else if (op == OP_ADDI)         state_d = S_ADDIEX;
                    else if (op == OP_BEQ)          state_d = S_BEQ;
                    else if (op == OP_J)            state_d = S_JUMP;
                    else begin
                        state_d   = S_ILLEGAL;
                        illegal_d = 1'b1;
                    end
                end
                // Load vs store is decided from the opcode latched in DECODE
                S_MEMADR: state_d = (opreg_q == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                S_EXEC:   state_d = S_ALUWB;
                S_ADDIEX: state_d = S_ADDIWB;
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP, S_ILLEGAL:
                          state_d = S_FETCH;
                default:  state_d = S_IDLE;   // unused encodings recover to IDLE
            endcase
        end
    end

    // Output logic (Moore, plus mem_ready qualifiers on the memory states)
    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // A paused FSM must not commit anything; mux selects stay as-is
        if (!en) begin
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            regwrite   = 1'b0;
            branch     = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: doc/maindec_mc.md
# maindec_mc

Multicycle main decoder, the sequential successor to the single-cycle `maindec`. It replaces the one-cycle opcode-to-control map with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. Memory accesses stall on a `mem_ready` handshake, and the opcode width and every opcode encoding are parameters. It sits in the CPU controller between the instruction register and the datapath/ALU decoder.

## Interface
- `OPW`, 4: opcode width, must be ≥ 4. Opcodes compare as full `OPW`-bit values.
- `OP_RTYPE`, 0: R-type opcode.
- `OP_ADDI`, 1: add-immediate opcode.
- `OP_LW`, 12: load-word opcode.
- `OP_SW`, 14: store-word opcode.
- `OP_BEQ`, 10: branch-if-equal opcode.
- `OP_J`, 8: jump opcode.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable. Low means hold state and force all write enables to 0.
- `op` in OPW: opcode from the instruction register. Sampled only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `memread`, `memwrite`, `irwrite`, `pcwrite`, `branch`, `iord`, `memtoreg`, `regdst`, `regwrite`, `alusrca` out 1: datapath controls.
- `alusrcb`, `aluop`, `pcsrc` out 2: datapath controls.
- `instr_done` out 1: one-cycle pulse in the final cycle of a legal instruction.
- `illegal` out 1: sticky flag, set by an unknown opcode.
- `state` out 4: current state, for debug.

## Operation
State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BEQ=9, ADDIEX=10, ADDIWB=11, JUMP=12, ILLEGAL=13.

Transitions:
- IDLE→FETCH.
- FETCH→DECODE when `mem_ready`, otherwise hold.
- DECODE latches `op` into the internal `opreg`, then branches:
  - LW or SW → MEMADR
  - RTYPE → EXEC
  - ADDI → ADDIEX
  - BEQ → BEQ
  - J → JUMP
  - any other value → ILLEGAL
- MEMADR→MEMRD if `opreg`=LW, else MEMWR.
- MEMRD→MEMWB when `mem_ready`, otherwise hold.
- MEMWR→FETCH when `mem_ready`, otherwise hold.
- EXEC→ALUWB. ADDIEX→ADDIWB.
- MEMWB, ALUWB, ADDIWB, BEQ, JUMP, ILLEGAL → FETCH.
- Encodings 14–15 → IDLE (recovery).

Outputs are Moore: a function of state, plus `mem_ready` where noted. Any output not listed for a state is 0.
- FETCH: `memread`=1, `alusrcb`=01; `irwrite`=`pcwrite`=`mem_ready`.
- DECODE: `alusrcb`=11.
- MEMADR: `alusrca`=1, `alusrcb`=10.
- MEMRD: `iord`=1, `memread`=1.
- MEMWB: `memtoreg`=1, `regwrite`=1, `instr_done`=1.
- MEMWR: `iord`=1, `memwrite`=1; `instr_done`=`mem_ready`.
- EXEC: `alusrca`=1, `aluop`=10.
- ALUWB: `regdst`=1, `regwrite`=1, `instr_done`=1.
- ADDIEX: `alusrca`=1, `alusrcb`=10.
- ADDIWB: `regwrite`=1, `instr_done`=1.
- BEQ: `alusrca`=1, `aluop`=01, `branch`=1, `pcsrc`=01, `instr_done`=1.
- JUMP: `pcsrc`=10, `pcwrite`=1, `instr_done`=1.
- ILLEGAL: all outputs 0 except `illegal`. The instruction is skipped.

Enable and flag rules:
- `en`=0: state and `opreg` hold. `irwrite`, `pcwrite`, `memwrite`, `regwrite`, `branch` and `instr_done` are forced to 0. Mux selects keep their state values.
- `illegal` is set on entry to ILLEGAL and stays set until reset.

## Timing
- Reset: `reset_n` low immediately sets state=IDLE, `opreg`=0 and `illegal`=0. All outputs are 0.
- First FETCH is one cycle after `reset_n` rises with `en`=1.
- Cycles FETCH→done with `mem_ready` held 1: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- A change on `op` outside DECODE has no effect.
- `mem_ready` asserted in a non-memory state is ignored.
- If `en` and `mem_ready` are both 1 in FETCH, the instruction register and PC load and the FSM advances in the same cycle.
- If `en`=0 and `mem_ready`=1 together, the access is not taken. The FSM holds and retries once `en` returns to 1.
- Reset asserted mid-instruction (for example in MEMWR) deasserts `memwrite` immediately and abandons the instruction.

## Test plan
- Reset, then release with `en`=1, `mem_ready`=1, `op`=4'b1100 → states 0,1,2,3,4,5,1. `regwrite`=1 and `memtoreg`=1 in MEMWB only; `instr_done` pulses once.
- `op`=4'b1110 with `mem_ready` low for 3 cycles in MEMWR → `memwrite`=1 and `iord`=1 for 4 cycles. `instr_done` is high only in the ready cycle, then FETCH.
- `op`=4'b0000 then 4'b1010 back-to-back → R-type: EXEC `aluop`=10, ALUWB `regdst`=1. BEQ: `branch`=1, `pcsrc`=01, `aluop`=01. FETCH-to-FETCH spacing 4 then 3 cycles.
- `op`=4'b0001 then 4'b1000 → ADDIEX `alusrcb`=10, ADDIWB `regwrite`=1 with `regdst`=0. JUMP: `pcwrite`=1, `pcsrc`=10.
- `op`=4'b0011 (illegal) → DECODE, ILLEGAL, FETCH. `illegal` goes to 1 and stays 1 across a following legal LW; `instr_done` stays 0 for the illegal instruction.
- `en` dropped for 2 cycles in MEMWR, then `reset_n` pulsed low during MEMRD → write enables are 0 and state holds while `en` is low. On reset, state=0, `memread`=0 and `illegal`=0 immediately.
